// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, arbiter state encoding and write-request payload for wb_port_arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS       = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } wb_arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: pipeline request, MDU handshake and register-file write port.
// pend_mask_o exists only when WB_SCOREBOARD_EN is defined.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                      pipe_we_i;
  logic [REG_ADDR_WIDTH-1:0] pipe_rd_addr_i;
  logic [DATA_WIDTH-1:0]     pipe_wb_data_i;
  logic                      pipe_stall_o;
  logic                      mdu_valid_i;
  logic [REG_ADDR_WIDTH-1:0] mdu_rd_addr_i;
  logic [DATA_WIDTH-1:0]     mdu_data_i;
  logic                      mdu_ready_o;
  logic                      rf_we_o;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0]     rf_wdata_o;
`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0]       pend_mask_o;
`endif

  modport slave (
    input  pipe_we_i, pipe_rd_addr_i, pipe_wb_data_i,
    input  mdu_valid_i, mdu_rd_addr_i, mdu_data_i,
    output pipe_stall_o, mdu_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o
`ifdef WB_SCOREBOARD_EN
    , output pend_mask_o
`endif
  );

  modport master (
    output pipe_we_i, pipe_rd_addr_i, pipe_wb_data_i,
    output mdu_valid_i, mdu_rd_addr_i, mdu_data_i,
    input  pipe_stall_o, mdu_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o
`ifdef WB_SCOREBOARD_EN
    , input pend_mask_o
`endif
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of wb_req_t; separate count register distinguishes full from empty.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered MDU results.
// Optional WB_SCOREBOARD_EN adds a per-register pending mask of buffered MDU results.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_port_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_arb_state_e        state_q, state_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  wb_req_t              head;
  wb_req_t              push_data;
  logic                 mdu_ready;
  logic                 push;
  logic                 grant_pipe;
  logic                 grant_fifo;
  logic                 unused_fifo_count;

  assign unused_fifo_count = ^fifo_count;

  // x0 results are acknowledged but never buffered.
  assign mdu_ready       = !rst_i && !fifo_full;
  assign push            = bus.mdu_valid_i && mdu_ready && (bus.mdu_rd_addr_i != '0);
  assign push_data       = '{addr: bus.mdu_rd_addr_i, data: bus.mdu_data_i};
  assign bus.mdu_ready_o = mdu_ready;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (grant_fifo),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grant selection, starvation tracking and write-port drive.
  always_comb begin
    state_d          = state_q;
    starve_d         = starve_q;
    grant_pipe       = 1'b0;
    grant_fifo       = 1'b0;
    bus.pipe_stall_o = 1'b0;
    bus.rf_we_o      = 1'b0;
    bus.rf_waddr_o   = '0;
    bus.rf_wdata_o   = '0;
    if (!rst_i) begin
      case (state_q)
        ARB_NORMAL: begin
          if (bus.pipe_we_i)    grant_pipe = 1'b1;
          else if (!fifo_empty) grant_fifo = 1'b1;
          if (fifo_empty || grant_fifo) starve_d = '0;
          else                          starve_d = starve_q + STARVE_W'(1);
          if (starve_d == STARVE_W'(STARVE_LIMIT)) state_d = ARB_FORCE;
        end
        ARB_FORCE: begin
          grant_fifo       = !fifo_empty;
          bus.pipe_stall_o = bus.pipe_we_i;
          starve_d         = '0;
          state_d          = ARB_NORMAL;
        end
        default: state_d = ARB_NORMAL;
      endcase
    end
    if (grant_pipe) begin
      bus.rf_we_o    = (bus.pipe_rd_addr_i != '0);
      bus.rf_waddr_o = bus.pipe_rd_addr_i;
      bus.rf_wdata_o = bus.pipe_wb_data_i;
    end else if (grant_fifo) begin
      bus.rf_we_o    = 1'b1;
      bus.rf_waddr_o = head.addr;
      bus.rf_wdata_o = head.data;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [CNT_W-1:0]    pend_cnt_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_mask;

  // Per-register count of buffered results; bit clears when the last one drains.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) pend_cnt_q[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if ((push && bus.mdu_rd_addr_i == REG_ADDR_WIDTH'(r)) &&
            !(grant_fifo && head.addr == REG_ADDR_WIDTH'(r)))
          pend_cnt_q[r] <= pend_cnt_q[r] + CNT_W'(1);
        else if (!(push && bus.mdu_rd_addr_i == REG_ADDR_WIDTH'(r)) &&
                 (grant_fifo && head.addr == REG_ADDR_WIDTH'(r)))
          pend_cnt_q[r] <= pend_cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) pend_mask[r] = (pend_cnt_q[r] != '0);
  end

  assign bus.pend_mask_o = pend_mask;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=8); WB_SCOREBOARD_EN adds mask checks.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.pipe_we_i      = pwe;
    bus.pipe_rd_addr_i = prd;
    bus.pipe_wb_data_i = pd;
    bus.mdu_valid_i    = mv;
    bus.mdu_rd_addr_i  = mrd;
    bus.mdu_data_i     = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic next();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    next();
    // Reset held for two cycles: everything quiet.
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_we",    64'(bus.rf_we_o),      64'd0);
      check("rst_ready", 64'(bus.mdu_ready_o),  64'd0);
      check("rst_stall", 64'(bus.pipe_stall_o), 64'd0);
      check("rst_waddr", 64'(bus.rf_waddr_o),   64'd0);
      next();
    end
    rst_i = 1'b0;
    #1;
    check("idle_we",    64'(bus.rf_we_o),      64'd0);
    check("idle_ready", 64'(bus.mdu_ready_o),  64'd1);
    check("idle_stall", 64'(bus.pipe_stall_o), 64'd0);
    next();

    // Pipeline priority over a buffered rd=7 result; no bypass on push cycle.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
    #1 check("push7_nobypass", 64'(bus.rf_we_o), 64'd0);
    next();
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    #1;
    check("prio_waddr", 64'(bus.rf_waddr_o), 64'd5);
    check("prio_wdata", 64'(bus.rf_wdata_o), 64'h1234);
    check("prio_we",    64'(bus.rf_we_o),    64'd1);
    check("prio_stall", 64'(bus.pipe_stall_o), 64'd0);
    next();
    idle();
    #1;
    check("drain7_we",    64'(bus.rf_we_o),    64'd1);
    check("drain7_waddr", 64'(bus.rf_waddr_o), 64'd7);
    check("drain7_wdata", 64'(bus.rf_wdata_o), 64'h77);
    next();
    #1 check("empty_we", 64'(bus.rf_we_o), 64'd0);
    next();

    // Backpressure with depth 2 under continuous pipeline writes.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA0);
    #1 check("bp_ready0", 64'(bus.mdu_ready_o), 64'd1);
    next();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'hB0);
    #1 check("bp_ready1", 64'(bus.mdu_ready_o), 64'd1);
    next();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC0);
    #1;
    check("bp_full_ready", 64'(bus.mdu_ready_o), 64'd0);
    check("bp_pipe_waddr", 64'(bus.rf_waddr_o),  64'd1);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0);
    #1;
    check("bp_hold_ready", 64'(bus.mdu_ready_o), 64'd0);
    check("bp_pop10",      64'(bus.rf_waddr_o),  64'd10);
    check("bp_pop10_data", 64'(bus.rf_wdata_o),  64'hA0);
    next();
    #1;
    check("bp_ready_again", 64'(bus.mdu_ready_o), 64'd1);
    check("bp_pop11",       64'(bus.rf_waddr_o),  64'd11);
    next();
    idle();
    #1;
    check("bp_pop12",      64'(bus.rf_waddr_o), 64'd12);
    check("bp_pop12_data", 64'(bus.rf_wdata_o), 64'hC0);
    next();
    #1 check("bp_empty_we", 64'(bus.rf_we_o), 64'd0);
    next();

    // Starvation: head rd=9 denied for 8 cycles, forced in the 9th.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    next();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
      #1;
      check("starve_pipe_waddr", 64'(bus.rf_waddr_o),   64'd2);
      check("starve_pipe_stall", 64'(bus.pipe_stall_o), 64'd0);
      next();
    end
    #1;
    check("force_waddr", 64'(bus.rf_waddr_o),   64'd9);
    check("force_wdata", 64'(bus.rf_wdata_o),   64'h99);
    check("force_stall", 64'(bus.pipe_stall_o), 64'd1);
    next();
    #1;
    check("after_force_waddr", 64'(bus.rf_waddr_o),   64'd2);
    check("after_force_stall", 64'(bus.pipe_stall_o), 64'd0);
    next();
    idle();
    #1 check("after_force_empty", 64'(bus.rf_we_o), 64'd0);
    next();

    // x0 handling.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    #1 check("x0_mdu_ready", 64'(bus.mdu_ready_o), 64'd1);
    next();
    idle();
    #1 check("x0_mdu_dropped", 64'(bus.rf_we_o), 64'd0);
    next();
    drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    #1;
    check("x0_pipe_we",    64'(bus.rf_we_o),      64'd0);
    check("x0_pipe_stall", 64'(bus.pipe_stall_o), 64'd0);
    next();

    // Reset mid-operation discards buffered rd=4.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
    next();
    idle();
    rst_i = 1'b1;
    #1;
    check("midrst_we",    64'(bus.rf_we_o),     64'd0);
    check("midrst_ready", 64'(bus.mdu_ready_o), 64'd0);
    next();
    rst_i = 1'b0;
    #1;
    check("postrst_we",    64'(bus.rf_we_o),     64'd0);
    check("postrst_ready", 64'(bus.mdu_ready_o), 64'd1);
    next();

`ifdef WB_SCOREBOARD_EN
    // Two buffered rd=3 results keep mask bit 3 set until the second drains.
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h31);
    #1 check("sb_initial", 64'(bus.pend_mask_o[3]), 64'd0);
    next();
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h32);
    #1 check("sb_one", 64'(bus.pend_mask_o[3]), 64'd1);
    next();
    idle();
    #1;
    check("sb_two",       64'(bus.pend_mask_o[3]), 64'd1);
    check("sb_pop1_data", 64'(bus.rf_wdata_o),     64'h31);
    next();
    #1;
    check("sb_after_pop1", 64'(bus.pend_mask_o[3]), 64'd1);
    check("sb_pop2_data",  64'(bus.rf_wdata_o),     64'h32);
    next();
    #1;
    check("sb_cleared", 64'(bus.pend_mask_o[3]), 64'd0);
    check("sb_bit0",    64'(bus.pend_mask_o[0]), 64'd0);
    next();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
